// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing defaults and flow-control FSM state encoding.
package fifo_pkg;
    localparam int DEF_MEM_SIZE = 4;
    localparam int DEF_PTR_L    = 3;
    localparam int DEF_HIGH_TH  = 3;
    localparam int DEF_LOW_TH   = 1;
    typedef enum logic {FF_ST_RUN = 1'b0, FF_ST_PAUSED = 1'b1} ff_state_t;
endpackage

// File: rtl/fifo_occupancy_cnt.sv
// fifo_occupancy_cnt: occupancy counter driven by qualified write/read strobes.
module fifo_occupancy_cnt
    import fifo_pkg::*;
#(
    parameter int PTR_L = DEF_PTR_L
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             wr_ok,
    input  logic             rd_ok,
    output logic [PTR_L-1:0] next_cnt,
    output logic [PTR_L-1:0] fifo_count
);
    // Strobes are pre-qualified by the full/empty flags, so this never wraps.
    always_comb next_cnt = fifo_count + PTR_L'(wr_ok) - PTR_L'(rd_ok);

    always_ff @(posedge clk) begin
        if (!reset_L) fifo_count <= '0;
        else          fifo_count <= next_cnt;
    end
endmodule

// File: rtl/fifo_flow_ctrl.sv
// fifo_flow_ctrl: occupancy flags and hysteresis pause for the FIFO.
// Define FIFO_FLOW_ERR_EN for sticky overflow/underflow flags; otherwise they are 0.
module fifo_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int PTR_L    = DEF_PTR_L,
    parameter int HIGH_TH  = DEF_HIGH_TH,
    parameter int LOW_TH   = DEF_LOW_TH
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             fifo_wr,
    input  logic             fifo_rd,
    output logic             push,
    output logic [PTR_L-1:0] fifo_count,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             pause,
    output logic             overflow,
    output logic             underflow
);
    localparam logic [PTR_L-1:0] FULL_C = PTR_L'(MEM_SIZE);
    localparam logic [PTR_L-1:0] AF_C   = PTR_L'(MEM_SIZE - 1);
    localparam logic [PTR_L-1:0] AE_C   = PTR_L'(1);
    localparam logic [PTR_L-1:0] HI_C   = PTR_L'(HIGH_TH);
    localparam logic [PTR_L-1:0] LO_C   = PTR_L'(LOW_TH);

    logic             wr_ok, rd_ok;
    logic [PTR_L-1:0] next_cnt;
    ff_state_t        state, state_nxt;

    assign wr_ok = fifo_wr & ~fifo_full;
    assign rd_ok = fifo_rd & ~fifo_empty;

    fifo_occupancy_cnt #(.PTR_L(PTR_L)) u_cnt (
        .clk        (clk),
        .reset_L    (reset_L),
        .wr_ok      (wr_ok),
        .rd_ok      (rd_ok),
        .next_cnt   (next_cnt),
        .fifo_count (fifo_count)
    );

    // Flags look ahead at next_cnt so they line up with fifo_count each cycle.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            push         <= 1'b0;
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_empty <= 1'b0;
            almost_full  <= 1'b0;
            state        <= FF_ST_RUN;
        end else begin
            push         <= wr_ok;
            fifo_empty   <= next_cnt == '0;
            fifo_full    <= next_cnt == FULL_C;
            almost_empty <= next_cnt <= AE_C;
            almost_full  <= next_cnt >= AF_C;
            state        <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == FF_ST_RUN && next_cnt >= HI_C)    state_nxt = FF_ST_PAUSED;
        if (state == FF_ST_PAUSED && next_cnt <= LO_C) state_nxt = FF_ST_RUN;
    end

    assign pause = state == FF_ST_PAUSED;

`ifdef FIFO_FLOW_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (fifo_wr & fifo_full);
            underflow <= underflow | (fifo_rd & fifo_empty);
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule
